// File: rtl/square_draw_ctrl_if.sv
// Request channel between the game FSM and the square draw controller.
//   req_valid  : request present (master -> slave)
//   req_ready  : controller can accept (slave -> master)
//   req_clear  : 1 = full-screen clear, 0 = tile draw
//   req_x/y    : tile top-left corner (ignored for clear)
//   req_colour : fill colour for tile or clear
interface square_draw_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_clear;
  logic [7:0] req_x;
  logic [6:0] req_y;
  logic [2:0] req_colour;

  modport master (
    output req_valid, req_clear, req_x, req_y, req_colour,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_clear, req_x, req_y, req_colour,
    output req_ready
  );
endinterface

// File: rtl/square_draw_ctrl.sv
// Square draw controller for the VGA pixel datapath.
// Takes one draw request (filled tile or full-screen clear) over the req
// channel and emits one pixel per clock into the VGA adapter write port.
//   clk, resetn : clock, synchronous active-low reset
//   req         : request channel (slave side)
//   plot        : pixel write enable
//   x_out/y_out : pixel coordinates
//   colour_out  : pixel colour
//   busy        : high while a request is in progress (TILE, CLEAR, DONE)
//   done        : one-cycle pulse when a request completes
//
// state  | meaning
// -------+--------------------------------------------------
// IDLE   | waiting for a request, req_ready high
// TILE   | scanning TILE_W x TILE_H pixels from (base_x, base_y)
// CLEAR  | scanning every visible pixel with the latched colour
// DONE   | completion pulse, then back to IDLE
module square_draw_ctrl #(
  parameter int TILE_W   = 16,
  parameter int TILE_H   = 16,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                 clk,
  input  logic                 resetn,
  square_draw_ctrl_if.slave    req,
  output logic                 plot,
  output logic [7:0]           x_out,
  output logic [6:0]           y_out,
  output logic [2:0]           colour_out,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {S_IDLE, S_TILE, S_CLEAR, S_DONE} state_t;

  localparam logic [7:0] TILE_X_LAST = 8'(TILE_W - 1);
  localparam logic [6:0] TILE_Y_LAST = 7'(TILE_H - 1);
  localparam logic [7:0] SCR_X_LAST  = 8'(SCREEN_W - 1);
  localparam logic [6:0] SCR_Y_LAST  = 7'(SCREEN_H - 1);
  localparam logic [8:0] SCR_W_LIM   = 9'(SCREEN_W);
  localparam logic [7:0] SCR_H_LIM   = 8'(SCREEN_H);

  state_t     state, state_nx;
  logic [7:0] cx, cx_nx;
  logic [6:0] cy, cy_nx;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [2:0] colour;
  logic       accept;

  // Sums are one bit wider than the screen coordinates so a tile that
  // runs past x=255 or y=127 is clipped instead of wrapping back on-screen.
  logic [8:0] sx;
  logic [7:0] sy;

  assign sx = {1'b0, base_x} + {1'b0, cx};
  assign sy = {1'b0, base_y} + {1'b0, cy};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= S_IDLE;
      cx     <= '0;
      cy     <= '0;
      base_x <= '0;
      base_y <= '0;
      colour <= '0;
    end else begin
      state <= state_nx;
      cx    <= cx_nx;
      cy    <= cy_nx;
      if (accept) begin
        base_x <= req.req_x;
        base_y <= req.req_y;
        colour <= req.req_colour;
      end
    end
  end

  always_comb begin
    state_nx      = state;
    cx_nx         = cx;
    cy_nx         = cy;
    accept        = 1'b0;
    req.req_ready = 1'b0;
    plot          = 1'b0;
    x_out         = '0;
    y_out         = '0;
    colour_out    = '0;
    busy          = 1'b0;
    done          = 1'b0;

    case (state)
      S_IDLE: begin
        req.req_ready = 1'b1;
        if (req.req_valid) begin
          accept   = 1'b1;
          cx_nx    = '0;
          cy_nx    = '0;
          state_nx = req.req_clear ? S_CLEAR : S_TILE;
        end
      end

      S_TILE: begin
        busy       = 1'b1;
        x_out      = sx[7:0];
        y_out      = sy[6:0];
        colour_out = colour;
        plot       = (sx < SCR_W_LIM) && (sy < SCR_H_LIM);
        if (cx == TILE_X_LAST) begin
          cx_nx = '0;
          if (cy == TILE_Y_LAST) begin
            cy_nx    = '0;
            state_nx = S_DONE;
          end else begin
            cy_nx = cy + 7'd1;
          end
        end else begin
          cx_nx = cx + 8'd1;
        end
      end

      S_CLEAR: begin
        busy       = 1'b1;
        x_out      = cx;
        y_out      = cy;
        colour_out = colour;
        plot       = 1'b1;
        if (cx == SCR_X_LAST) begin
          cx_nx = '0;
          if (cy == SCR_Y_LAST) begin
            cy_nx    = '0;
            state_nx = S_DONE;
          end else begin
            cy_nx = cy + 7'd1;
          end
        end else begin
          cx_nx = cx + 8'd1;
        end
      end

      S_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = S_IDLE;
      end

      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_square_draw_ctrl.sv
// Testbench for square_draw_ctrl: a default 16x16 instance and a 4x4
// instance, checked against a pixel-list model built from plain loops.
module tb_square_draw_ctrl;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  square_draw_ctrl_if rq0 ();
  square_draw_ctrl_if rq1 ();

  logic       plot0, busy0, done0, plot1, busy1, done1;
  logic [7:0] x0, x1;
  logic [6:0] y0, y1;
  logic [2:0] c0, c1;

  square_draw_ctrl u_dut0 (
    .clk(clk), .resetn(resetn), .req(rq0),
    .plot(plot0), .x_out(x0), .y_out(y0), .colour_out(c0),
    .busy(busy0), .done(done0)
  );

  square_draw_ctrl #(.TILE_W(4), .TILE_H(4)) u_dut1 (
    .clk(clk), .resetn(resetn), .req(rq1),
    .plot(plot1), .x_out(x1), .y_out(y1), .colour_out(c1),
    .busy(busy1), .done(done1)
  );

  int checks = 0;
  int failures = 0;

  int obs_x[$], obs_y[$], obs_c[$];
  int exp_x[$], exp_y[$];
  int pix_cycles, done_cyc, ready_cyc;
  bit ready_while_busy, idle_nonzero;

  task automatic sample(input bit which, output logic p, output logic [7:0] x,
                        output logic [6:0] y, output logic [2:0] c,
                        output logic b, output logic d, output logic r);
    if (!which) begin
      p = plot0; x = x0; y = y0; c = c0; b = busy0; d = done0; r = rq0.req_ready;
    end else begin
      p = plot1; x = x1; y = y1; c = c1; b = busy1; d = done1; r = rq1.req_ready;
    end
  endtask

  task automatic issue(input bit which, input bit clr, input logic [7:0] x,
                       input logic [6:0] y, input logic [2:0] col, input bit hold);
    @(negedge clk);
    if (!which) begin
      rq0.req_clear = clr; rq0.req_x = x; rq0.req_y = y; rq0.req_colour = col;
      rq0.req_valid = 1'b1;
    end else begin
      rq1.req_clear = clr; rq1.req_x = x; rq1.req_y = y; rq1.req_colour = col;
      rq1.req_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      rq0.req_valid = 1'b0;
      rq1.req_valid = 1'b0;
    end
  endtask

  // Records the output stream for cycles 1.. after an accept, up to and
  // including the first ready cycle following done. Optionally scrambles
  // req_x every cycle (after sampling) to show it is ignored while busy.
  task automatic collect(input bit which, input int max_cyc, input bit scramble);
    logic p, b, d, r;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    obs_x.delete(); obs_y.delete(); obs_c.delete();
    pix_cycles = 0; done_cyc = -1; ready_cyc = -1;
    ready_while_busy = 0; idle_nonzero = 0;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clk);
      sample(which, p, x, y, c, b, d, r);
      if (b && r) ready_while_busy = 1;
      if (p) begin
        obs_x.push_back(int'(x)); obs_y.push_back(int'(y)); obs_c.push_back(int'(c));
      end
      if (b && !d) pix_cycles++;
      if (d && done_cyc < 0) done_cyc = k;
      if (scramble) rq0.req_x = 8'($urandom);
      if (r && done_cyc >= 0) begin
        ready_cyc = k;
        if (p || x != 0 || y != 0 || c != 0) idle_nonzero = 1;
        break;
      end
    end
  endtask

  // Reference: every pixel the request should write, in raster order.
  task automatic build_exp(input bit clr, input int bx, input int by,
                           input int w, input int h);
    exp_x.delete(); exp_y.delete();
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++) begin
        if (clr) begin
          exp_x.push_back(xx); exp_y.push_back(yy);
        end else if (bx + xx < 160 && by + yy < 120) begin
          exp_x.push_back(bx + xx); exp_y.push_back(by + yy);
        end
      end
  endtask

  function automatic int first_diff(input int col);
    int n;
    n = (obs_x.size() < exp_x.size()) ? obs_x.size() : exp_x.size();
    for (int i = 0; i < n; i++)
      if (obs_x[i] != exp_x[i] || obs_y[i] != exp_y[i] || obs_c[i] != col) return i;
    if (obs_x.size() != exp_x.size()) return n;
    return -1;
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    checks++;
    if ({plot0, busy0, done0, rq0.req_ready, x0, y0, c0} !== {3'b000, 1'b1, 18'd0}) begin
      failures++;
      $display("FAIL reset_dut0: got p=%b b=%b d=%b r=%b x=%0d y=%0d c=%0d expected 0,0,0,1,0,0,0",
               plot0, busy0, done0, rq0.req_ready, x0, y0, c0);
    end
    checks++;
    if ({plot1, busy1, done1, rq1.req_ready, x1, y1, c1} !== {3'b000, 1'b1, 18'd0}) begin
      failures++;
      $display("FAIL reset_dut1: got p=%b b=%b d=%b r=%b expected 0,0,0,1",
               plot1, busy1, done1, rq1.req_ready);
    end
  endtask

  task automatic test_tile_basic();
    int idx;
    issue(0, 0, 8'd10, 7'd20, 3'b100, 0);
    collect(0, 400, 0);
    build_exp(0, 10, 20, 16, 16);
    checks++;
    if (obs_x.size() !== 256) begin
      failures++; $display("FAIL tile_plots: got %0d expected 256", obs_x.size());
    end
    checks++;
    if ({obs_x[0], obs_y[0], obs_x[1], obs_y[1]} !== {32'd10, 32'd20, 32'd11, 32'd20}) begin
      failures++;
      $display("FAIL tile_first_two: got (%0d,%0d) (%0d,%0d) expected (10,20) (11,20)",
               obs_x[0], obs_y[0], obs_x[1], obs_y[1]);
    end
    checks++;
    if ({obs_x[16], obs_y[16], obs_x[255], obs_y[255]} !== {32'd10, 32'd21, 32'd25, 32'd35}) begin
      failures++;
      $display("FAIL tile_17th_last: got (%0d,%0d) (%0d,%0d) expected (10,21) (25,35)",
               obs_x[16], obs_y[16], obs_x[255], obs_y[255]);
    end
    idx = first_diff(4);
    checks++;
    if (idx !== -1) begin
      failures++; $display("FAIL tile_stream: first bad pixel index %0d expected none", idx);
    end
    checks++;
    if (done_cyc !== 257 || ready_cyc !== 258) begin
      failures++;
      $display("FAIL tile_timing: got done=%0d ready=%0d expected 257 258", done_cyc, ready_cyc);
    end
    checks++;
    if (ready_while_busy !== 0 || idle_nonzero !== 0) begin
      failures++;
      $display("FAIL tile_handshake: got rdy_busy=%0d idle_nz=%0d expected 0 0",
               ready_while_busy, idle_nonzero);
    end
  endtask

  task automatic test_clip();
    int idx;
    issue(0, 0, 8'd150, 7'd110, 3'b010, 0);
    collect(0, 400, 0);
    build_exp(0, 150, 110, 16, 16);
    idx = first_diff(2);
    checks++;
    if (obs_x.size() !== 100 || idx !== -1) begin
      failures++;
      $display("FAIL clip_corner: got plots=%0d bad_idx=%0d expected 100 -1", obs_x.size(), idx);
    end
    checks++;
    if (pix_cycles !== 256 || done_cyc !== 257) begin
      failures++;
      $display("FAIL clip_timing: got pix=%0d done=%0d expected 256 257", pix_cycles, done_cyc);
    end
    issue(0, 0, 8'd250, 7'd0, 3'b111, 0);
    collect(0, 400, 0);
    checks++;
    if (obs_x.size() !== 0 || done_cyc !== 257) begin
      failures++;
      $display("FAIL clip_x_wrap: got plots=%0d done=%0d expected 0 257", obs_x.size(), done_cyc);
    end
  endtask

  task automatic test_clear();
    int idx;
    issue(0, 1, 8'd77, 7'd33, 3'b001, 0);
    collect(0, 19300, 0);
    build_exp(1, 0, 0, 160, 120);
    idx = first_diff(1);
    checks++;
    if (obs_x.size() !== 19200 || idx !== -1) begin
      failures++;
      $display("FAIL clear_stream: got plots=%0d bad_idx=%0d expected 19200 -1", obs_x.size(), idx);
    end
    checks++;
    if (done_cyc !== 19201 || ready_cyc !== 19202) begin
      failures++;
      $display("FAIL clear_timing: got done=%0d ready=%0d expected 19201 19202", done_cyc, ready_cyc);
    end
  endtask

  task automatic test_back_to_back();
    int idx;
    logic [7:0] second_x;
    issue(0, 0, 8'd30, 7'd40, 3'b011, 1);
    collect(0, 400, 1);
    build_exp(0, 30, 40, 16, 16);
    idx = first_diff(3);
    checks++;
    if (idx !== -1) begin
      failures++; $display("FAIL b2b_first_stream: first bad pixel index %0d expected none", idx);
    end
    checks++;
    if (ready_while_busy !== 0 || done_cyc !== 257 || ready_cyc !== 258) begin
      failures++;
      $display("FAIL b2b_first_handshake: got rdy_busy=%0d done=%0d ready=%0d expected 0 257 258",
               ready_while_busy, done_cyc, ready_cyc);
    end
    second_x = rq0.req_x;
    @(posedge clk);
    #1 rq0.req_valid = 1'b0;
    collect(0, 400, 0);
    build_exp(0, int'(second_x), 40, 16, 16);
    idx = first_diff(3);
    checks++;
    if (idx !== -1 || done_cyc !== 257) begin
      failures++;
      $display("FAIL b2b_second: got bad_idx=%0d done=%0d expected -1 257 (x=%0d)",
               idx, done_cyc, second_x);
    end
  endtask

  task automatic test_reset_mid_tile();
    int idx;
    bit saw_done;
    issue(0, 0, 8'd40, 7'd30, 3'b110, 0);
    repeat (50) @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    checks++;
    if ({plot0, busy0, rq0.req_ready, done0} !== 4'b0010) begin
      failures++;
      $display("FAIL abort_state: got p=%b b=%b r=%b d=%b expected 0 0 1 0",
               plot0, busy0, rq0.req_ready, done0);
    end
    saw_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (done0) saw_done = 1;
    end
    checks++;
    if (saw_done !== 0) begin
      failures++; $display("FAIL abort_no_done: got done pulse=%0d expected 0", saw_done);
    end
    issue(0, 0, 8'd0, 7'd0, 3'b101, 0);
    collect(0, 400, 0);
    build_exp(0, 0, 0, 16, 16);
    idx = first_diff(5);
    checks++;
    if (obs_x.size() !== 256 || idx !== -1 || done_cyc !== 257) begin
      failures++;
      $display("FAIL abort_redraw: got plots=%0d bad_idx=%0d done=%0d expected 256 -1 257",
               obs_x.size(), idx, done_cyc);
    end
  endtask

  task automatic test_small_tile();
    int idx;
    issue(1, 0, 8'd5, 7'd6, 3'b010, 0);
    collect(1, 100, 0);
    build_exp(0, 5, 6, 4, 4);
    idx = first_diff(2);
    checks++;
    if (obs_x.size() !== 16 || idx !== -1) begin
      failures++;
      $display("FAIL small_stream: got plots=%0d bad_idx=%0d expected 16 -1", obs_x.size(), idx);
    end
    checks++;
    if (done_cyc !== 17 || ready_cyc !== 18) begin
      failures++;
      $display("FAIL small_timing: got done=%0d ready=%0d expected 17 18", done_cyc, ready_cyc);
    end
  endtask

  task automatic test_random();
    int idx, w;
    bit which;
    logic [7:0] rx;
    logic [6:0] ry;
    logic [2:0] rc;
    for (int n = 0; n < 8; n++) begin
      which = 1'($urandom_range(0, 1));
      w = which ? 4 : 16;
      rx = 8'($urandom); ry = 7'($urandom); rc = 3'($urandom);
      issue(which, 0, rx, ry, rc, 0);
      collect(which, 400, 0);
      build_exp(0, int'(rx), int'(ry), w, w);
      idx = first_diff(int'(rc));
      checks++;
      if (idx !== -1 || pix_cycles !== w * w || done_cyc !== w * w + 1 || ready_cyc !== w * w + 2) begin
        failures++;
        $display("FAIL random_tile[%0d]: dut%0d (%0d,%0d) got bad_idx=%0d pix=%0d done=%0d ready=%0d expected -1 %0d %0d %0d",
                 n, which, rx, ry, idx, pix_cycles, done_cyc, ready_cyc, w * w, w * w + 1, w * w + 2);
      end
    end
  endtask

  initial begin
    rq0.req_valid = 1'b0; rq0.req_clear = 1'b0; rq0.req_x = '0; rq0.req_y = '0; rq0.req_colour = '0;
    rq1.req_valid = 1'b0; rq1.req_clear = 1'b0; rq1.req_x = '0; rq1.req_y = '0; rq1.req_colour = '0;
    test_reset();
    test_tile_basic();
    test_clip();
    test_clear();
    test_back_to_back();
    test_reset_mid_tile();
    test_small_tile();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
